// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - SPI slave receiver with synchronised inputs and a show-ahead receive FIFO
module spi_rx_fifo #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SPI_MODE   = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              Sclk,
  input  logic              Mosi,
  input  logic              CSel,
  input  logic              DataRead,
  input  logic              OvrClr,
  output logic [WORD_W-1:0] DataOut,
  output logic              DataValid,
  output logic              FifoFull,
  output logic              Overrun,
  output logic              FrameActive,
  output logic              FrameEnd,
  output logic              PartialErr
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  // Modes 0 and 3 (CPOL == CPHA) sample on the rising edge, modes 1 and 2 on the falling edge
  localparam bit SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic csel_meta_q, csel_sync_q, csel_prev_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] shifted;
  logic              push_pend_q, push_pend_d;
  logic [WORD_W-1:0] push_word_q, push_word_d;
  logic              frame_active_q, frame_active_d;
  logic              frame_end_q, frame_end_d;
  logic              partial_err_q, partial_err_d;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              fifo_full_q, fifo_full_d;
  logic              overrun_q, overrun_d;

  logic sample_edge, csel_fall;
  logic fifo_empty, fifo_full_now, pop, push_ok, drop;

  // Two-flop synchronisers, plus one history flop on Sclk and CSel for edge detection
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      csel_meta_q <= 1'b0;
      csel_sync_q <= 1'b0;
      csel_prev_q <= 1'b0;
    end else begin
      sclk_meta_q <= Sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= Mosi;
      mosi_sync_q <= mosi_meta_q;
      csel_meta_q <= CSel;
      csel_sync_q <= csel_meta_q;
      csel_prev_q <= csel_sync_q;
    end
  end

  // Edge detection on synchronised copies and the next shift-register value
  always_comb begin
    sample_edge = SAMPLE_RISE ? (sclk_sync_q & ~sclk_prev_q) : (~sclk_sync_q & sclk_prev_q);
    // A falling edge needs a high history bit, so a frame already open at reset release is skipped
    csel_fall   = csel_prev_q & ~csel_sync_q;
    if (MSB_FIRST != 0) shifted = {shift_q[WORD_W-2:0], mosi_sync_q};
    else                shifted = {mosi_sync_q, shift_q[WORD_W-1:1]};
  end

  // Frame FSM, bit assembly and frame-boundary pulses
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_pend_d   = 1'b0;
    push_word_d   = push_word_q;
    frame_end_d   = 1'b0;
    partial_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csel_fall) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (csel_sync_q) begin
          state_d       = ST_IDLE;
          frame_end_d   = 1'b1;
          partial_err_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          shift_d       = '0;
        end else if (sample_edge) begin
          shift_d = shifted;
          if (bit_cnt_q == LAST_BIT) begin
            // Word complete: hand it to the FIFO next cycle and start the next word at once
            bit_cnt_d   = '0;
            push_pend_d = 1'b1;
            push_word_d = shifted;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    frame_active_d = (state_d == ST_ACTIVE);
  end

  // FIFO pointer arithmetic, overrun handling and the registered show-ahead head
  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    fifo_full_now = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop           = DataRead && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word
    push_ok       = push_pend_q && (!fifo_full_now || pop);
    drop          = push_pend_q && fifo_full_now && !pop;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push_ok);
    data_valid_d  = (rd_ptr_d != wr_ptr_d);
    fifo_full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    data_out_d    = data_out_q;
    if (data_valid_d) begin
      // The new head is either already stored or is the word being written this cycle
      if (rd_ptr_d == wr_ptr_q) data_out_d = push_word_q;
      else                      data_out_d = mem_q[rd_ptr_d[AW-1:0]];
    end
    // Set has priority over clear
    if (drop)        overrun_d = 1'b1;
    else if (OvrClr) overrun_d = 1'b0;
    else             overrun_d = overrun_q;
  end

  // FIFO storage; contents only matter behind valid pointers, so no reset is needed
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word_q;
  end

  // Control state, pointers and registered outputs
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      push_pend_q    <= 1'b0;
      push_word_q    <= '0;
      frame_active_q <= 1'b0;
      frame_end_q    <= 1'b0;
      partial_err_q  <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      fifo_full_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      push_pend_q    <= push_pend_d;
      push_word_q    <= push_word_d;
      frame_active_q <= frame_active_d;
      frame_end_q    <= frame_end_d;
      partial_err_q  <= partial_err_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      fifo_full_q    <= fifo_full_d;
      overrun_q      <= overrun_d;
    end
  end

  assign DataOut     = data_out_q;
  assign DataValid   = data_valid_q;
  assign FifoFull    = fifo_full_q;
  assign Overrun     = overrun_q;
  assign FrameActive = frame_active_q;
  assign FrameEnd    = frame_end_q;
  assign PartialErr  = partial_err_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb/tb_spi_rx_fifo.sv - scoreboard bench for spi_rx_fifo over all SPI modes and both bit orders
module tb_spi_rx_fifo;
  localparam int N = 4;  // instance g runs SPI mode g; instance 3 is LSB-first
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_lead = 1'b0;
  logic mosi = 1'b0;
  logic csel = 1'b1;
  logic [N-1:0] data_read = '0;
  logic [N-1:0] ovr_clr = '0;
  logic [W-1:0] data_out [N];
  logic [N-1:0] data_valid, fifo_full, overrun, frame_active, frame_end, partial_err;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q [N][$];
  logic ovr_m [N] = '{default: 1'b0};
  logic [W-1:0] last_out [N] = '{default: '0};
  int fe_cnt [N] = '{default: 0};
  int pe_cnt [N] = '{default: 0};
  int fe_base [N] = '{default: 0};
  int pe_base [N] = '{default: 0};
  logic [W-1:0] cur_word = '0;
  int bit_in_word = 0;
  logic in_frame = 1'b0;
  logic lat_chk = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam logic CPOL = (g >= 2);
    logic sclk_g;
    assign sclk_g = sclk_lead ^ CPOL;
    spi_rx_fifo #(.WORD_W(W), .FIFO_DEPTH(D), .SPI_MODE(g), .MSB_FIRST(g == 3 ? 0 : 1)) u_dut (
      .Clk(clk), .RstN(rst_n), .Sclk(sclk_g), .Mosi(mosi), .CSel(csel),
      .DataRead(data_read[g]), .OvrClr(ovr_clr[g]), .DataOut(data_out[g]),
      .DataValid(data_valid[g]), .FifoFull(fifo_full[g]), .Overrun(overrun[g]),
      .FrameActive(frame_active[g]), .FrameEnd(frame_end[g]), .PartialErr(partial_err[g]));
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Word as seen by instance g, given wire bits with the first-sent bit in position W-1
  function automatic logic [W-1:0] model_word(int g, logic [W-1:0] wire_bits);
    logic [W-1:0] r;
    if (g != 3) return wire_bits;
    for (int i = 0; i < W; i++) r[i] = wire_bits[W-1-i];
    return r;
  endfunction

  task automatic model_bit(logic b);
    if (!in_frame) return;
    cur_word = {cur_word[W-2:0], b};
    bit_in_word++;
    if (bit_in_word == W) begin
      bit_in_word = 0;
      for (int g = 0; g < N; g++) begin
        if (exp_q[g].size() < D) exp_q[g].push_back(model_word(g, cur_word));
        else ovr_m[g] = 1'b1;
      end
    end
  endtask

  // Count cycles each pulse output is high
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (frame_end[g]) fe_cnt[g] <= fe_cnt[g] + 1;
      if (partial_err[g]) pe_cnt[g] <= pe_cnt[g] + 1;
    end
  end

  // Monitor: every read request is a pop from the scoreboard or must see an empty FIFO
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        for (int g = 0; g < N; g++) begin
          if (data_read[g]) begin
            if (exp_q[g].size() > 0) begin
              check($sformatf("pop_valid[%0d]", g), 32'(data_valid[g]), 32'd1);
              check($sformatf("pop_data[%0d]", g), 32'(data_out[g]), 32'(exp_q[g][0]));
              last_out[g] = exp_q[g].pop_front();
            end else begin
              check($sformatf("empty_read[%0d]", g), 32'(data_valid[g]), 32'd0);
            end
          end
        end
      end
    end
  end

  // Each bit takes 10 Clk: Mosi at c=0, leading edge at c=1, trailing edge at c=5.
  // pulse_kind 1/2 raises DataRead/OvrClr exactly in the push cycle of the last bit's word.
  task automatic send_bits(logic [31:0] bits, int n, int pulse_kind);
    logic [N-1:0] grp;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        data_read = '0;
        ovr_clr = '0;
        if (c == 0) mosi = bits[n-1-i];
        if (c == 1) sclk_lead = 1'b1;
        if (c == 5) sclk_lead = 1'b0;
        if (i == n-1 && pulse_kind != 0 && (c == 4 || c == 8)) begin
          grp = (c == 4) ? 4'b0101 : 4'b1010;
          if (pulse_kind == 1) data_read = grp;
          else ovr_clr = grp;
        end
        if (lat_chk && i == n-1 && c == 5) begin
          check("latency_valid_mode0", 32'(data_valid[0]), 32'd1);
          check("latency_valid_mode2", 32'(data_valid[2]), 32'd1);
        end
      end
      model_bit(bits[n-1-i]);
    end
  endtask

  task automatic status_check(string tag);
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s_valid[%0d]", tag, g), 32'(data_valid[g]), 32'(exp_q[g].size() > 0));
      check($sformatf("%s_full[%0d]", tag, g), 32'(fifo_full[g]), 32'(exp_q[g].size() == D));
      check($sformatf("%s_overrun[%0d]", tag, g), 32'(overrun[g]), 32'(ovr_m[g]));
      if (exp_q[g].size() > 0)
        check($sformatf("%s_head[%0d]", tag, g), 32'(data_out[g]), 32'(exp_q[g][0]));
    end
  endtask

  task automatic frame_open();
    for (int g = 0; g < N; g++) begin
      fe_base[g] = fe_cnt[g];
      pe_base[g] = pe_cnt[g];
    end
    @(negedge clk);
    csel = 1'b0;
    in_frame = 1'b1;
    bit_in_word = 0;
    repeat (4) @(negedge clk);
    check("frame_active_open", 32'(frame_active), 32'hF);
  endtask

  task automatic frame_close(string tag);
    logic partial;
    repeat (3) @(negedge clk);
    csel = 1'b1;
    partial = (bit_in_word != 0);
    in_frame = 1'b0;
    bit_in_word = 0;
    repeat (6) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s_frame_end[%0d]", tag, g), 32'(fe_cnt[g] - fe_base[g]), 32'd1);
      check($sformatf("%s_partial[%0d]", tag, g), 32'(pe_cnt[g] - pe_base[g]), 32'(partial));
    end
    check($sformatf("%s_frame_active", tag), 32'(frame_active), 32'h0);
    status_check(tag);
  endtask

  task automatic drain(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      data_read = '1;
      @(negedge clk);
      data_read = '0;
    end
    @(negedge clk);
    for (int g = 0; g < N; g++)
      if (exp_q[g].size() == 0)
        check($sformatf("hold_out[%0d]", g), 32'(data_out[g]), 32'(last_out[g]));
  endtask

  task automatic clear_ovr();
    @(negedge clk);
    ovr_clr = '1;
    @(negedge clk);
    ovr_clr = '0;
    for (int g = 0; g < N; g++) ovr_m[g] = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'h0);
  endtask

  task automatic reset_check(string tag);
    for (int g = 0; g < N; g++)
      check($sformatf("%s_data_out[%0d]", tag, g), 32'(data_out[g]), 32'h0);
    check($sformatf("%s_flags", tag),
          {8'h0, data_valid, fifo_full, overrun, frame_active, frame_end, partial_err}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    reset_check("midreset");
    for (int g = 0; g < N; g++) begin
      exp_q[g].delete();
      ovr_m[g] = 1'b0;
      last_out[g] = '0;
    end
    in_frame = 1'b0;
    bit_in_word = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_check("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single word with latency check
    lat_chk = 1'b1;
    frame_open();
    send_bits(32'hA5, 8, 0);
    lat_chk = 1'b0;
    frame_close("a5");
    drain(1);

    // Palindromic pattern, same result for every mode and bit order
    frame_open();
    send_bits(32'h3C, 8, 0);
    frame_close("3c");
    drain(1);

    // Overflow: fifth word dropped
    frame_open();
    for (int w = 1; w <= 5; w++) send_bits(32'(w), 8, 0);
    frame_close("ovf");
    drain(5);
    clear_ovr();

    // Full FIFO with a pop in the push cycle
    frame_open();
    for (int w = 0; w < 4; w++) send_bits(32'h10 + 32'(w), 8, 0);
    frame_close("fill");
    frame_open();
    send_bits(32'h5A, 8, 1);
    frame_close("pushpop");
    drain(5);

    // Drop coinciding with OvrClr keeps Overrun set
    frame_open();
    for (int w = 0; w < 4; w++) send_bits(32'h20 + 32'(w), 8, 0);
    frame_close("fill2");
    frame_open();
    send_bits(32'h99, 8, 2);
    frame_close("setwins");
    drain(4);
    clear_ovr();

    // Partial word then a clean frame
    frame_open();
    send_bits(32'h5B3, 11, 0);
    frame_close("partial");
    frame_open();
    send_bits(32'h7E, 8, 0);
    frame_close("after_partial");
    drain(3);

    // Reset mid-frame after two words and four bits
    frame_open();
    send_bits(32'hC33C, 16, 0);
    send_bits(32'hA, 4, 0);
    do_reset();
    send_bits(32'h5, 4, 0);
    check("no_reentry_active", 32'(frame_active), 32'h0);
    repeat (3) @(negedge clk);
    csel = 1'b1;
    repeat (6) @(negedge clk);
    for (int g = 0; g < N; g++)
      check($sformatf("no_frame_end_after_reset[%0d]", g), 32'(fe_cnt[g] - fe_base[g]), 32'd0);
    check("no_words_after_reset", 32'(data_valid), 32'h0);
    frame_open();
    send_bits(32'h81, 8, 0);
    frame_close("post_reset");
    drain(2);

    // Randomised frames and drains
    for (int it = 0; it < 40; it++) begin
      frame_open();
      send_bits($urandom, $urandom_range(1, 24), 0);
      frame_close("rand");
      drain($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) clear_ovr();
    end
    drain(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
